// File: rtl/modulo_product_param.sv
// rtl/modulo_product_param.sv - handshaked iterative modular product: y*2^k mod N (SHIFT) or a*b mod N (MUL)
// Optional operand check (a >= N -> immediate err) enabled by MODPROD_ERR_CHECK_EN.
module modulo_product_param #(
  parameter int W  = 256,
  parameter int KW = $clog2(W + 1) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [W-1:0]  N,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] k,
  input  logic          abort,
  output logic [W-1:0]  result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_n, r_a, r_b, r_result;
  logic          r_mode;
  logic [W:0]    r_acc;
  logic [KW-1:0] r_cnt;

  logic [W+1:0]  w_n_ext, w_dbl, w_dbl_red, w_sum, w_sum_red, w_acc_nxt;
  logic          w_bad, w_direct_done, w_last;

`ifdef MODPROD_ERR_CHECK_EN
  logic r_err;
  assign w_bad = (a >= N);
  assign err   = r_err;
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign result        = r_result;
  assign w_direct_done = w_bad || (!mode && (k == '0));
  assign w_last        = (r_cnt == KW'(1));

  // One double-and-add step; two guard bits keep 2*acc + a exact before reduction.
  always_comb begin
    w_n_ext   = {2'b00, r_n};
    w_dbl     = {1'b0, r_acc} << 1;
    w_dbl_red = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    w_sum     = w_dbl_red + {2'b00, r_a};
    w_sum_red = (w_sum >= w_n_ext) ? (w_sum - w_n_ext) : w_sum;
    w_acc_nxt = (r_mode && r_b[W-1]) ? w_sum_red : w_dbl_red;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = w_direct_done ? S_DONE : S_RUN;
      S_RUN:   if (abort) w_state_nxt = S_IDLE;
               else if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (abort || out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef MODPROD_ERR_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_n    <= N;
          r_a    <= a;
          r_b    <= b;
          r_mode <= mode;
          r_acc  <= mode ? '0 : {1'b0, a};
          r_cnt  <= mode ? KW'(W) : k;
          if (w_bad)              r_result <= '0;
          else if (w_direct_done) r_result <= a;
`ifdef MODPROD_ERR_CHECK_EN
          r_err  <= w_bad;
`endif
        end
        S_RUN: if (!abort) begin
          r_acc <= (W+1)'(w_acc_nxt);
          r_b   <= {r_b[W-2:0], 1'b0};
          r_cnt <= r_cnt - KW'(1);
          if (w_last) r_result <= W'(w_acc_nxt);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_product_param.sv
// tb/tb_modulo_product_param.sv - randomized/directed bench for modulo_product_param (W=8 and W=256)
module tb_modulo_product_param;
  localparam int W   = 8;
  localparam int KW  = $clog2(W + 1) + 1;
  localparam int W2  = 256;
  localparam int KW2 = $clog2(W2 + 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 0, in_ready, mode = 0, abort = 0, out_valid, out_ready = 0, err;
  logic [W-1:0]  N = 0, a = 0, b = 0, result;
  logic [KW-1:0] k = 0;

  logic           in_valid2 = 0, in_ready2, mode2 = 0, abort2 = 0, out_valid2, out_ready2 = 0, err2;
  logic [W2-1:0]  N2 = 0, a2 = 0, b2 = 0, result2;
  logic [KW2-1:0] k2 = 0;

  modulo_product_param #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .N(N), .a(a), .b(b), .k(k), .abort(abort), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  modulo_product_param #(.W(W2)) dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .mode(mode2),
    .N(N2), .a(a2), .b(b2), .k(k2), .abort(abort2), .result(result2),
    .out_valid(out_valid2), .out_ready(out_ready2), .err(err2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic m, input logic [W-1:0] n, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic [KW-1:0] kk);
    chk("in_ready_before_accept", in_ready, 1);
    mode = m; N = n; a = aa; b = bb; k = kk; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    mode = 1'($urandom); N = W'($urandom); a = W'($urandom); b = W'($urandom); k = KW'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic op_check(input string tag, input logic m, input logic [W-1:0] n, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [KW-1:0] kk,
                          input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    start(m, n, aa, bb, kk);
    wait_done(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_err"}, err, 0);
    pop;
    chk({tag, "_out_valid_after_pop"}, out_valid, 0);
    chk({tag, "_in_ready_after_pop"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] held;
    logic seen;
    logic [W2-1:0] n256, exp256;
    longint unsigned mm, aa, bb, nn;
    int kk;
    logic md;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_err", err, 0);
    rst = 0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset256_result", result2, 0);
    @(posedge clk); #1;

    op_check("mul_7x9_mod13", 1, 13, 7, 9, 0, 11, W);
    op_check("shift_5_k8_mod13", 0, 13, 5, 0, 8, 6, 8);
    op_check("shift_5_k0_mod13", 0, 13, 5, 0, 0, 5, 0);

    // Back-pressure in DONE
    start(1, 13, 12, 12, 0);
    wait_done(lat);
    chk("bp_latency", lat, W);
    held = result;
    chk("bp_result", held, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_result_stable", result, held);
      chk("bp_out_valid_held", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_err_stable", err, 0);
    end
    pop;
    chk("bp_out_valid_dropped", out_valid, 0);

    // Abort at RUN cycle 3, then a fresh operation
    start(1, 13, 7, 9, 0);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_no_result", seen, 0);
    op_check("after_abort_12x12", 1, 13, 12, 12, 0, 1, W);

    // Abort held high in IDLE does not block acceptance
    abort = 1;
    start(0, 13, 5, 0, 3);
    abort = 0;
    wait_done(lat);
    chk("idle_abort_latency", lat, 3);
    chk("idle_abort_result", result, 1);
    // Abort and out_ready together in DONE
    abort = 1; out_ready = 1;
    @(posedge clk); #1;
    abort = 0; out_ready = 0;
    chk("abort_vs_ready_out_valid", out_valid, 0);
    chk("abort_vs_ready_in_ready", in_ready, 1);

    // Randomized operations against arithmetic reference
    for (int i = 0; i < 24; i++) begin
      nn = longint'($urandom_range(1, 255));
      aa = longint'($urandom_range(0, 32'(nn - 1)));
      bb = longint'($urandom_range(0, 255));
      kk = $urandom_range(0, 31);
      md = 1'($urandom);
      if (md) mm = (aa * bb) % nn;
      else    mm = (aa << kk) % nn;
      op_check($sformatf("rand%0d_%s", i, md ? "mul" : "shift"), md, W'(nn), W'(aa), W'(bb), KW'(kk),
               W'(mm), md ? W : kk);
    end

    // Operand check
    start(0, 13, 13, 0, 5);
    wait_done(lat);
`ifdef MODPROD_ERR_CHECK_EN
    chk("errchk_latency", lat, 0);
    chk("errchk_result", result, 0);
    chk("errchk_err", err, 1);
`else
    chk("errchk_latency", lat, 5);
    chk("errchk_err", err, 0);
`endif
    pop;

    // Asynchronous reset while holding a result
    start(1, 200, 199, 199, 0);
    wait_done(lat);
    chk("prerst_result", result, (199 * 199) % 200);
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // W=256 boundary: 2*acc exceeds 2^W
    n256 = '0; n256[W2-1] = 1'b1; n256[0] = 1'b1;
    exp256 = '1; exp256[W2-1] = 1'b0;
    chk("w256_in_ready", in_ready2, 1);
    mode2 = 0; N2 = n256; a2 = 1; k2 = KW2'(256); in_valid2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0; N2 = '0; a2 = '1;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 600) begin @(posedge clk); #1; lat++; end
    chk("w256_shift_latency", lat, 256);
    chk("w256_shift_result", result2, exp256);
    chk("w256_shift_err", err2, 0);
    out_ready2 = 1; @(posedge clk); #1; out_ready2 = 0;

    mode2 = 1; N2 = 13; a2 = 7; b2 = 9; in_valid2 = 1;
    @(posedge clk); #1;
    in_valid2 = 0;
    lat = 0;
    while (out_valid2 !== 1'b1 && lat < 600) begin @(posedge clk); #1; lat++; end
    chk("w256_mul_latency", lat, 256);
    chk("w256_mul_result", result2, 11);
    out_ready2 = 1; @(posedge clk); #1; out_ready2 = 0;
    chk("w256_out_valid_after_pop", out_valid2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
